chunk_serial_addsub: RTL and testbench



---
 rtl/chunk_serial_addsub_pkg.sv | 16 +
 rtl/chunk_serial_addsub_add.sv | 22 ++
 rtl/chunk_serial_addsub.sv | 122 ++++++++++++
 tb/tb_chunk_serial_addsub.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_serial_addsub_pkg.sv
// Shared types and helpers for the chunk-serial adder/subtractor.
// Holds the control state encoding and the chunk-counter sizing rule.
package chunk_serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_serial_addsub_add.sv
// Combinational CHUNK-bit adder slice with carry-out and carry into the top bit.
// The top-bit carry-in lets the parent form signed overflow on the final chunk.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    assign full  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    assign s     = full[CHUNK-1:0];
    assign co    = full[CHUNK];
    // The sum bit is x^y^cin, so the carry into the top bit can be recovered from it.
    assign c_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/chunk_serial_addsub.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock,
// keeping the inter-chunk carry in a register, with valid/ready on both sides.
module chunk_serial_addsub
    import chunk_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cntWidth(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] chunkA, chunkB, chunkS;
    logic             chunkCo, chunkCmsb;
    int               base;

    assign base   = int'(cnt_q) * CHUNK;
    assign chunkA = a_q[base +: CHUNK];
    assign chunkB = b_q[base +: CHUNK];

    chunk_add #(.CHUNK(CHUNK)) u_add (
        .x     (chunkA),
        .y     (chunkB),
        .ci    (carry_q),
        .s     (chunkS),
        .co    (chunkCo),
        .c_msb (chunkCmsb)
    );

    // Subtraction is a + ~b + ~cin: B is stored inverted and the carry seeded with cin^sub.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: CHUNK] = chunkS;
                carry_d = chunkCo;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = chunkCo;
                    ovf_d   = chunkCmsb ^ chunkCo;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunk_serial_addsub.sv
// Scoreboard bench for chunk_serial_addsub: a 16/4 instance for the main cases
// and an 8/8 single-chunk instance for back-to-back throughput.
module tb_chunk_serial_addsub;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        inValid, inReady, outValid, outReady;
    logic [15:0] aIn, bIn, sumOut;
    logic        subIn, cinIn, coutOut, ovfOut;

    logic        inValid8, inReady8, outValid8, outReady8;
    logic [7:0]  aIn8, bIn8, sumOut8;
    logic        subIn8, cinIn8, coutOut8, ovfOut8;

    exp_t sb16[$];
    exp_t sb8[$];
    int   testsRun;
    int   testsFailed;
    int   cyc;

    chunk_serial_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid), .in_ready(inReady),
        .a(aIn), .b(bIn), .sub(subIn), .cin(cinIn),
        .out_valid(outValid), .out_ready(outReady),
        .sum(sumOut), .cout(coutOut), .ovf(ovfOut)
    );

    chunk_serial_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid8), .in_ready(inReady8),
        .a(aIn8), .b(bIn8), .sub(subIn8), .cin(cinIn8),
        .out_valid(outValid8), .out_ready(outReady8),
        .sum(sumOut8), .cout(coutOut8), .ovf(ovfOut8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic: overflow from operand/result signs, independent of carries.
    function automatic exp_t model(input int w, input logic [15:0] ta, input logic [15:0] tb,
                                   input logic ts, input logic tc);
        exp_t   e;
        longint mask, bb, full;
        mask  = (longint'(1) << w) - 1;
        bb    = ts ? (~longint'(tb) & mask) : longint'(tb);
        full  = longint'(ta) + bb + longint'(ts ? !tc : tc);
        e.sum = 16'(full & mask);
        e.cout = full[w];
        e.ovf = (ta[w-1] == bb[w-1]) && (e.sum[w-1] != ta[w-1]);
        e.acc = 0;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Result comparisons happen on the handshake, wherever the driver happens to be.
    always @(negedge clk) begin
        if (rst_n && outValid && outReady) begin
            if (sb16.size() == 0) begin
                checkOutput("sb16_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb16.pop_front();
                checkOutput("sum16", 32'(sumOut), 32'(e.sum));
                checkOutput("cout16", 32'(coutOut), 32'(e.cout));
                checkOutput("ovf16", 32'(ovfOut), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && outValid8 && outReady8) begin
            if (sb8.size() == 0) begin
                checkOutput("sb8_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                checkOutput("sum8", 32'(sumOut8), 32'(e.sum[7:0]));
                checkOutput("cout8", 32'(coutOut8), 32'(e.cout));
                checkOutput("ovf8", 32'(ovfOut8), 32'(e.ovf));
                checkOutput("latency8", 32'(cyc - e.acc), 32'd1);
            end
        end
    end

    task automatic waitReady16();
        int guard;
        guard = 0;
        while (!inReady && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("in_ready16_wait", 32'(inReady), 32'd1);
    endtask

    // One 16-bit operation: accept, latency, optional backpressure hold, then handshake.
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic ts, input logic tc, input int hold);
        exp_t e;
        int   lat;
        waitReady16();
        aIn = ta; bIn = tb; subIn = ts; cinIn = tc; inValid = 1'b1;
        e = model(16, ta, tb, ts, tc);
        sb16.push_back(e);
        @(posedge clk); #1;
        inValid = 1'b0;
        aIn = 16'($urandom); bIn = 16'($urandom);
        subIn = 1'($urandom); cinIn = 1'($urandom);
        lat = 0;
        while (!outValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency16", 32'(lat), 32'd4);
        for (int i = 0; i < hold; i++) begin
            inValid = 1'($urandom_range(0, 1));
            aIn = 16'($urandom); bIn = 16'($urandom);
            @(posedge clk); #1;
            checkOutput("hold_sum16", 32'(sumOut), 32'(e.sum));
            checkOutput("hold_cout16", 32'(coutOut), 32'(e.cout));
            checkOutput("hold_ovf16", 32'(ovfOut), 32'(e.ovf));
            checkOutput("hold_in_ready16", 32'(inReady), 32'd0);
            checkOutput("hold_out_valid16", 32'(outValid), 32'd1);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("idle_in_ready16", 32'(inReady), 32'd1);
        checkOutput("idle_out_valid16", 32'(outValid), 32'd0);
    endtask

    initial begin
        logic [7:0] opA[4];
        logic [7:0] opB[4];
        logic       opS[4];
        logic       opC[4];
        int         prevAcc;
        int         guard;
        exp_t       e;

        testsRun = 0; testsFailed = 0; cyc = 0;
        rst_n = 1'b0;
        inValid = 0; outReady = 0; aIn = 0; bIn = 0; subIn = 0; cinIn = 0;
        inValid8 = 0; outReady8 = 0; aIn8 = 0; bIn8 = 0; subIn8 = 0; cinIn8 = 0;
        #12;
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_sum", 32'(sumOut), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 5);
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0, 0);
        applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0, 2);
        applyStimulus(16'h0010, 16'h0001, 1'b1, 1'b1, 0);
        applyStimulus(16'hA5C3, 16'h5A3C, 1'b0, 1'b1, 0);

        // Abort at chunk 2 with a non-zero partial sum already written.
        waitReady16();
        aIn = 16'hFFFF; bIn = 16'h1111; subIn = 0; cinIn = 0; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(outValid), 32'd0);
        checkOutput("abort_sum", 32'(sumOut), 32'd0);
        checkOutput("abort_cout", 32'(coutOut), 32'd0);
        checkOutput("abort_ovf", 32'(ovfOut), 32'd0);
        checkOutput("abort_in_ready", 32'(inReady), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

        // Single-chunk instance, consumer always ready, producer always offering.
        opA = '{8'h7F, 8'h05, 8'h80, 8'hFF};
        opB = '{8'h01, 8'h03, 8'h01, 8'hFF};
        opS = '{1'b0, 1'b1, 1'b1, 1'b0};
        opC = '{1'b0, 1'b0, 1'b0, 1'b1};
        outReady8 = 1'b1;
        prevAcc = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (!inReady8 && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            checkOutput("in_ready8_wait", 32'(inReady8), 32'd1);
            aIn8 = opA[i]; bIn8 = opB[i]; subIn8 = opS[i]; cinIn8 = opC[i];
            inValid8 = 1'b1;
            @(posedge clk); #1;
            e = model(8, {8'h00, opA[i]}, {8'h00, opB[i]}, opS[i], opC[i]);
            e.acc = cyc;
            sb8.push_back(e);
            if (i > 0) checkOutput("interval8", 32'(cyc - prevAcc), 32'd3);
            prevAcc = cyc;
        end
        inValid8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("sb16_drained", 32'(sb16.size()), 32'd0);
        checkOutput("sb8_drained", 32'(sb8.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
